regfile_write_arbiter: RTL and testbench

Sequencer and arbiter for the register file's single write port. After reset, or on command, it zeroes every register through the write port. Otherwise it shares the write port among N writeback requesters using round-robin valid/ready arbitration. It sits between the writeback sources (ALU, load unit, debug) and the register file's `address3`/`write_data`/`write_enable` inputs, and drives them from registers.

---
 rtl/regfile_write_arbiter.sv | 75 +++++++
 tb/tb_regfile_write_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zeroes the register file on reset or command, then round-robin arbitrates its single write port.
module regfile_write_arbiter #(
    parameter int D       = 5,
    parameter int W       = 32,
    parameter int N       = 3,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear_start,
    input  logic [N-1:0]   req_valid,
    input  logic [N*D-1:0] req_addr,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           busy,
    output logic [D-1:0]   rf_address3,
    output logic [W-1:0]   rf_write_data,
    output logic           rf_write_enable
);
    localparam int PW = $clog2(N);
    typedef enum logic {CLEAR, ARB} state_t;
    state_t state, state_nx;
    logic [D-1:0] cnt;
    logic [PW-1:0] ptr, gnt_idx;
    logic [PW:0] cand;
    logic hs;
    logic [D-1:0] gnt_addr;
    logic [W-1:0] gnt_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= CLEAR;
        else state <= state_nx;
    always_comb
        state_nx = state == CLEAR ? (&cnt ? ARB : CLEAR) : (clear_start ? CLEAR : ARB);
    // Scan downward so the last hit is the first valid requester at or after ptr.
    always_comb begin
        gnt_idx = '0;
        hs = 1'b0;
        cand = '0;
        if (state == ARB && !clear_start)
            for (int k = N - 1; k >= 0; k--) begin
                cand = {1'b0, ptr} + (PW+1)'(k);
                cand = cand >= (PW+1)'(N) ? cand - (PW+1)'(N) : cand;
                if (req_valid[cand[PW-1:0]]) begin
                    gnt_idx = cand[PW-1:0];
                    hs = 1'b1;
                end
            end
    end
    always_comb begin
        busy = state == CLEAR;
        req_ready = hs ? {{(N-1){1'b0}}, 1'b1} << gnt_idx : '0;
    end
    assign gnt_addr = req_addr[int'(gnt_idx)*D +: D];
    assign gnt_data = req_data[int'(gnt_idx)*W +: W];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_address3 <= '0;
            rf_write_data <= '0;
            cnt <= '0;
            ptr <= '0;
        end else if (state == CLEAR) begin
            rf_write_enable <= 1'b1;
            rf_address3 <= cnt;
            rf_write_data <= '0;
            cnt <= cnt + 1'b1;
        end else if (hs) begin
            rf_write_enable <= !(ZERO_R0 && gnt_addr == '0);
            rf_address3 <= gnt_addr;
            rf_write_data <= gnt_data;
            ptr <= gnt_idx == PW'(N - 1) ? '0 : gnt_idx + 1'b1;
        end else begin
            rf_write_enable <= 1'b0;
        end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench; a requester-level model predicts grants and register-file writes.
module tb_regfile_write_arbiter;
    localparam int D = 5, W = 32, N = 3, NR = 1 << D;
    localparam bit ZR0 = 1'b1;
    typedef struct {logic [D-1:0] a; logic [W-1:0] d; int due;} wr_t;
    logic clk = 0, rst = 0, clear_start = 0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*D-1:0] req_addr = '0;
    logic [N*W-1:0] req_data = '0;
    logic busy, rf_write_enable;
    logic [D-1:0] rf_address3;
    logic [W-1:0] rf_write_data;
    logic [W-1:0] dut_rf [NR];
    logic [W-1:0] exp_rf [NR];
    logic pend [N];
    logic [D-1:0] pa [N];
    logic [W-1:0] pd [N];
    wr_t q[$];
    int cyc = 0, checks = 0, errors = 0, mptr = 0, clear_left = 0;
    regfile_write_arbiter #(.D(D), .W(W), .N(N), .ZERO_R0(ZR0)) dut (
        .clk(clk), .rst(rst), .clear_start(clear_start), .req_valid(req_valid),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready), .busy(busy),
        .rf_address3(rf_address3), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (rf_write_enable) dut_rf[rf_address3] <= rf_write_data;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    initial forever begin
        wr_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("write", {31'd0, rf_write_enable, rf_address3, rf_write_data}, {31'd0, 1'b1, e.a, e.d});
            end else if (rf_write_enable) begin
                chk("unexpected_write", {32'd0, rf_address3, rf_write_data}, 64'd0);
            end
        end
    end
    task automatic start_clear(input int first_due);
        for (int i = 0; i < NR; i++) begin
            q.push_back('{D'(i), '0, first_due + i});
            exp_rf[i] = '0;
        end
        clear_left = NR;
    endtask
    task automatic do_reset();
        rst = 1;
        q.delete();
        repeat (2) @(negedge clk);
        mptr = 0;
        start_clear(cyc + 1);
        rst = 0;
    endtask
    task automatic step(input logic cs);
        int g;
        logic [N-1:0] er;
        clear_start = cs;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_addr[i*D +: D] = pa[i];
            req_data[i*W +: W] = pd[i];
        end
        #1;
        g = -1;
        if (clear_left == 0 && !cs)
            for (int k = 0; k < N; k++) begin
                int i = (mptr + k) % N;
                if (g < 0 && pend[i]) g = i;
            end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("busy", 64'(busy), 64'(clear_left > 0));
        chk("req_ready", 64'(req_ready), 64'(er));
        if (g >= 0) begin
            if (!(ZR0 && pa[g] == '0)) begin
                q.push_back('{pa[g], pd[g], cyc + 1});
                exp_rf[pa[g]] = pd[g];
            end
            mptr = (g + 1) % N;
            pend[g] = 0;
        end
        if (clear_left > 0) clear_left--;
        else if (cs) start_clear(cyc + 2);
        @(negedge clk);
    endtask
    function automatic int nonzero_regs();
        int n = 0;
        for (int i = 0; i < NR; i++) if (dut_rf[i] !== '0) n++;
        return n;
    endfunction
    task automatic set_req(input int i, input int a, input logic [W-1:0] d);
        pend[i] = 1;
        pa[i] = D'(a);
        pd[i] = d;
    endtask
    initial begin
        for (int i = 0; i < N; i++) begin pend[i] = 0; pa[i] = '0; pd[i] = '0; end
        req_valid = '1;
        #2 rst = 1;
        #1;
        chk("rst_we", 64'(rf_write_enable), 0);
        chk("rst_addr", 64'(rf_address3), 0);
        chk("rst_data", 64'(rf_write_data), 0);
        chk("rst_busy", 64'(busy), 1);
        chk("rst_ready", 64'(req_ready), 0);
        do_reset();
        repeat (NR + 1) step(0);
        chk("reset_clear_zero", 64'(nonzero_regs()), 0);
        set_req(1, 5, 32'hDEADBEEF);
        step(0);
        step(0);
        chk("single_write_r5", 64'(dut_rf[5]), 64'hDEADBEEF);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, 10 + 3 * n + i, 32'h100 * n + i);
            step(0);
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        step(0);
        set_req(2, 20, 32'h2222);
        step(0);
        set_req(0, 21, 32'h3333);
        set_req(1, 22, 32'h4444);
        set_req(2, 23, 32'h5555);
        repeat (3) step(0);
        step(0);
        chk("rr_r23", 64'(dut_rf[23]), 64'h5555);
        set_req(0, 0, 32'h1234);
        step(0);
        step(0);
        chk("zero_r0", 64'(dut_rf[0]), 0);
        set_req(0, 7, 32'hAA);
        step(0);
        set_req(2, 9, 32'h55);
        step(1);
        chk("collision_r7", 64'(dut_rf[7]), 64'hAA);
        repeat (NR) step(0);
        chk("after_clear_r7", 64'(dut_rf[7]), 0);
        step(0);
        step(0);
        chk("collision_r9", 64'(dut_rf[9]), 64'h55);
        step(1);
        repeat (13) step(0);
        chk("pre_rst_addr", 64'(rf_address3), 12);
        chk("pre_rst_we", 64'(rf_write_enable), 1);
        rst = 1;
        #1;
        chk("mid_rst_we", 64'(rf_write_enable), 0);
        do_reset();
        repeat (NR + 1) step(0);
        chk("mid_rst_clear_zero", 64'(nonzero_regs()), 0);
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) set_req(i, $urandom_range(0, NR - 1), $urandom);
                else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 0;
            step($urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (NR + 4) step(0);
        chk("queue_drained", 64'(q.size()), 0);
        for (int i = 0; i < NR; i++) chk($sformatf("rf[%0d]", i), 64'(dut_rf[i]), 64'(exp_rf[i]));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
